sensor_poll_seq: RTL and testbench
==================================

Name: sensor_poll_seq

Overview:
- AXI-lite master that drives the I2C sensor bridge (slave ports axi_*, b_*) to sample the 0x76 environmental sensor without CPU involvement.
- Each sample has three phases:
  - Two configuration writes: ctrl_hum then ctrl_meas.
  - A conversion wait.
  - A burst of single-byte reads from consecutive sensor registers, packed into a snapshot register.
- Runs one-shot on start, or periodically while enable is high.
- Sits between the system control logic and the sensor bridge.

Parameters:
- NREAD, 8, number of consecutive sensor registers read per sample (1..16).
- BASE_REG, 8'hF7, first sensor register read.
- HUM_REG, 8'hF2, register written with cfg_ctrl_hum.
- MEAS_REG, 8'hF4, register written with cfg_ctrl_meas.
- CONV_CYCLES, 32'd4_000_000, clk cycles waited after the second write completes.
- PERIOD_CYCLES, 32'd83_000_000, clk cycles from one sample's DONE to the next sample start while enable=1.
- TIMEOUT_CYCLES, 32'd50_000_000, watchdog limit for any single wait on ready/valid.

Ports:
- clk  in  1  system clock (same domain as the bridge).
- rst  in  1  synchronous, active-low reset.
- enable  in  1  periodic sampling enable.
- start  in  1  single-cycle pulse; request one sample now.
- cfg_ctrl_hum  in  8  data written to HUM_REG.
- cfg_ctrl_meas  in  8  data written to MEAS_REG.
- axi_araddr  out  32  read address = {22'd0, reg, 2'b00}.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready.
- axi_rdata  in  32  bit 8 = NACK flag, bits [7:0] = data byte.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data ready.
- axi_awaddr  out  32  write address = {22'd0, reg, 2'b00}.
- axi_awvalid  out  1  write address valid.
- axi_awready  in  1  write address ready.
- axi_wdata  out  32  write data = {24'd0, byte}.
- axi_wvalid  out  1  write data valid.
- axi_wready  in  1  write data ready.
- b_ready  out  1  write response ready.
- b_valid  in  1  write response valid.
- busy  out  1  high in every state except IDLE and PERIOD_WAIT.
- sample_data  out  8*NREAD  snapshot; byte i (bits 8i+7:8i) = register BASE_REG+i.
- sample_valid  out  1  one-cycle pulse when sample_data updates.
- sample_count  out  16  completed samples; wraps 0xFFFF->0.
- nack_err  out  1  sticky; set if any read returned rdata[8]=1. Cleared by reset or by a start pulse.
- timeout_err  out  1  sticky; set on watchdog expiry. Cleared by reset or by a start pulse.

Behaviour:
- Reset (rst=0 at posedge):
  - All valid/ready outputs 0; addresses and wdata 0.
  - sample_data 0, sample_valid 0, sample_count 0, both error flags 0.
  - State IDLE, all counters 0.
  - Reset has priority mid-transaction; the bridge is expected to be reset in the same cycle.
- Handshakes:
  - A channel transfer occurs at the posedge where valid&&ready are both 1.
  - valid, address and data are held stable until that transfer.
  - axi_rready and b_ready are asserted only in their response states.
- States and transitions:
  - IDLE -> WR_A: on start=1, or enable=1 (the first sample starts immediately). Load wr_idx=0.
  - WR_A:
    - Drive awvalid/wvalid together: wr_idx 0 -> HUM_REG/cfg_ctrl_hum, wr_idx 1 -> MEAS_REG/cfg_ctrl_meas.
    - Config inputs are sampled on entry to WR_A.
    - Each valid deasserts independently on its own transfer; both channels are allowed to transfer in the same cycle.
    - -> WR_B once both have transferred.
  - WR_B:
    - b_ready=1.
    - On b_valid: if wr_idx=0, set wr_idx=1 and go to WR_A; otherwise go to CONV_WAIT.
  - CONV_WAIT: count CONV_CYCLES cycles -> RD_A with rd_idx=0.
  - RD_A: arvalid=1, araddr for BASE_REG+rd_idx; -> RD_R on transfer.
  - RD_R:
    - rready=1.
    - On rvalid: capture rdata[7:0] into shadow byte rd_idx; if rdata[8]=1, set nack_err.
    - If rd_idx=NREAD-1 go to DONE; otherwise increment rd_idx and go to RD_A.
  - DONE (1 cycle):
    - Copy shadow to sample_data; pulse sample_valid; sample_count+1.
    - -> PERIOD_WAIT if enable=1, else IDLE.
  - PERIOD_WAIT:
    - Count PERIOD_CYCLES, then go to WR_A.
    - enable=0 -> IDLE immediately.
    - start=1 -> WR_A immediately.
- Register arithmetic: BASE_REG+rd_idx is an 8-bit sum and wraps mod 256; no error is raised.
- start while busy is ignored; the errors are not cleared in that case.
- Watchdog:
  - Counts cycles in WR_A, WR_B, RD_A and RD_R; resets on each state change.
  - At TIMEOUT_CYCLES: set timeout_err, drop all valids/readies, go to IDLE.
  - No sample_valid is generated and sample_data is unchanged.
- sample_data changes only in DONE, so a partial sample is never visible.

Test Plan:
- Bench setup for all scenarios:
  - CONV_CYCLES=20, PERIOD_CYCLES=200, TIMEOUT_CYCLES=500, NREAD=8.
  - Behavioural bridge slave returns byte = reg^8'h5A, with 3 cycles of I2C latency.
- One-shot sample:
  - Stimulus: start pulse, cfg_ctrl_hum=8'h01, cfg_ctrl_meas=8'h27.
  - Expected: awaddr 0x3C8/wdata 0x01, then awaddr 0x3D0/wdata 0x27.
  - Expected: 8 reads at araddr 0x3DC..0x3F8.
  - Expected: sample_data byte0=0xAD ... byte7=0xA4; one sample_valid pulse; sample_count=1; returns to IDLE.
- Periodic: hold enable=1 for 3 samples.
  - Expected: exactly 200 cycles from each DONE to the next WR_A; sample_count=3.
  - Drop enable in PERIOD_WAIT -> IDLE; no 4th write.
- Split handshakes:
  - Stimulus: slave asserts wready 5 cycles before awready.
  - Expected: wvalid drops after its transfer, awvalid holds until its own transfer; exactly one write per register.
- NACK:
  - Stimulus: slave sets rdata[8]=1 on the 3rd read.
  - Expected: nack_err=1, the sample still completes, sample_valid pulses.
  - Expected: the next start pulse clears nack_err.
- Timeout:
  - Stimulus: slave never asserts rvalid.
  - Expected: timeout_err=1 after 500 cycles in RD_R, IDLE, sample_data unchanged, no sample_valid.
- Reset mid-read:
  - Stimulus: rst=0 for 1 cycle during RD_R.
  - Expected: all outputs at reset values on the next cycle, sample_count=0.

Source files
------------

// File: rtl/sensor_poll_seq_if.sv
// AXI-lite style channels between the sensor poll sequencer (master) and the I2C sensor bridge (slave).
// Latency: none, wires only.
// Backpressure: each channel transfers on a posedge where its valid and ready are both high.
interface sensor_poll_seq_if;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        b_ready;
  logic        b_valid;

  modport master (
    output axi_araddr, axi_arvalid, axi_rready,
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, b_ready,
    input  axi_arready, axi_rdata, axi_rvalid,
    input  axi_awready, axi_wready, b_valid
  );

  modport slave (
    input  axi_araddr, axi_arvalid, axi_rready,
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, b_ready,
    output axi_arready, axi_rdata, axi_rvalid,
    output axi_awready, axi_wready, b_valid
  );
endinterface

// File: rtl/sensor_poll_seq.sv
// Autonomous sensor sampler: two config writes, conversion wait, NREAD byte reads packed into a snapshot.
// Latency: one sample = 2 write transactions + CONV_CYCLES + NREAD read transactions + 1 cycle.
// Backpressure: holds valid/address/data until the bridge accepts; a watchdog aborts any stalled wait.
module sensor_poll_seq #(
  parameter int          NREAD          = 8,
  parameter logic [7:0]  BASE_REG       = 8'hF7,
  parameter logic [7:0]  HUM_REG        = 8'hF2,
  parameter logic [7:0]  MEAS_REG       = 8'hF4,
  parameter logic [31:0] CONV_CYCLES    = 32'd4_000_000,
  parameter logic [31:0] PERIOD_CYCLES  = 32'd83_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic [7:0]           cfg_ctrl_hum,
  input  logic [7:0]           cfg_ctrl_meas,
  sensor_poll_seq_if.master    bus,
  output logic                 busy,
  output logic [8*NREAD-1:0]   sample_data,
  output logic                 sample_valid,
  output logic [15:0]          sample_count,
  output logic                 nack_err,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, CONV_WAIT, RD_A, RD_R, DONE, PERIOD_WAIT
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NREAD - 1);

  state_t              state, state_nxt;
  logic [31:0]         cnt;
  logic                wr_idx;
  logic [3:0]          rd_idx;
  logic [3:0]          rd_next;
  logic                aw_done, w_done;
  logic                aw_fire, w_fire, ar_fire;
  logic                watched, timed, wd_expire;
  logic [31:0]         aw_addr, w_data, ar_addr;
  logic [8*NREAD-1:0]  shadow;
  logic                unused_rdata;

  assign unused_rdata = ^bus.axi_rdata[31:9];

  assign aw_fire = bus.axi_awvalid && bus.axi_awready;
  assign w_fire  = bus.axi_wvalid  && bus.axi_wready;
  assign ar_fire = bus.axi_arvalid && bus.axi_arready;

  assign watched = (state == WR_A) || (state == WR_B) || (state == RD_A) || (state == RD_R);
  assign timed   = (state != IDLE) && (state != DONE);
  assign rd_next = (state == RD_R) ? rd_idx + 4'd1 : 4'd0;

  // Channel outputs follow the state; each write valid retires on its own transfer.
  assign bus.axi_awvalid = (state == WR_A) && !aw_done;
  assign bus.axi_wvalid  = (state == WR_A) && !w_done;
  assign bus.b_ready     = (state == WR_B);
  assign bus.axi_arvalid = (state == RD_A);
  assign bus.axi_rready  = (state == RD_R);
  assign bus.axi_awaddr  = aw_addr;
  assign bus.axi_wdata   = w_data;
  assign bus.axi_araddr  = ar_addr;
  assign busy            = (state != IDLE) && (state != PERIOD_WAIT);

  // Next-state selection, with the watchdog overriding any wait that made no progress.
  always_comb begin
    state_nxt = state;
    wd_expire = 1'b0;
    case (state)
      IDLE:        if (start || enable) state_nxt = WR_A;
      WR_A:        if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WR_B;
      WR_B:        if (bus.b_valid) state_nxt = wr_idx ? CONV_WAIT : WR_A;
      CONV_WAIT:   if (cnt == CONV_CYCLES - 32'd1) state_nxt = RD_A;
      RD_A:        if (ar_fire) state_nxt = RD_R;
      RD_R:        if (bus.axi_rvalid) state_nxt = (rd_idx == LAST_IDX) ? DONE : RD_A;
      DONE:        state_nxt = enable ? PERIOD_WAIT : IDLE;
      PERIOD_WAIT: begin
        if (start)                                state_nxt = WR_A;
        else if (!enable)                         state_nxt = IDLE;
        else if (cnt == PERIOD_CYCLES - 32'd1)    state_nxt = WR_A;
      end
      default:     state_nxt = IDLE;
    endcase
    if (watched && (state_nxt == state) && (cnt == TIMEOUT_CYCLES - 32'd1)) begin
      state_nxt = IDLE;
      wd_expire = 1'b1;
    end
  end

  // State, counters, transaction registers, snapshot and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_idx       <= 1'b0;
      rd_idx       <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      ar_addr      <= '0;
      shadow       <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      sample_count <= '0;
      nack_err     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= (!timed || state_nxt != state) ? 32'd0 : cnt + 32'd1;
      sample_valid <= 1'b0;

      // Config bytes are captured as each write begins.
      if (state_nxt == WR_A && state != WR_A) begin
        wr_idx  <= (state == WR_B);
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        aw_addr <= {22'd0, (state == WR_B) ? MEAS_REG : HUM_REG, 2'b00};
        w_data  <= {24'd0, (state == WR_B) ? cfg_ctrl_meas : cfg_ctrl_hum};
      end else if (state == WR_A) begin
        aw_done <= aw_done || aw_fire;
        w_done  <= w_done  || w_fire;
      end

      // Register index wraps modulo 256 by construction of the 8-bit sum.
      if (state_nxt == RD_A && state != RD_A) begin
        rd_idx  <= rd_next;
        ar_addr <= {22'd0, BASE_REG + {4'd0, rd_next}, 2'b00};
      end

      if (state == RD_R && bus.axi_rvalid) begin
        for (int i = 0; i < NREAD; i++) begin
          if (rd_idx == 4'(i)) shadow[i*8 +: 8] <= bus.axi_rdata[7:0];
        end
        if (bus.axi_rdata[8]) nack_err <= 1'b1;
      end

      if (state == DONE) begin
        sample_data  <= shadow;
        sample_valid <= 1'b1;
        sample_count <= sample_count + 16'd1;
      end

      if (wd_expire) timeout_err <= 1'b1;

      if (start && (state == IDLE || state == PERIOD_WAIT)) begin
        nack_err    <= 1'b0;
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sensor_poll_seq.sv
// Bench for sensor_poll_seq: behavioural bridge slave, transfer logging, reference sample model.
// Latency: slave answers reads/writes 3 cycles after acceptance.
// Backpressure: per-channel ready delays are configurable and randomized.
module tb_sensor_poll_seq;
  localparam int         NREAD = 8;
  localparam logic [7:0] BASE  = 8'hF7;
  localparam logic [7:0] HUMR  = 8'hF2;
  localparam logic [7:0] MEASR = 8'hF4;
  localparam int         LAT   = 3;
  localparam int         PERIOD = 200;
  localparam int         TMO   = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, start;
  logic [7:0]  hum, meas;
  logic        busy, sample_valid, nack_err, timeout_err;
  logic [63:0] sample_data;
  logic [15:0] sample_count;

  sensor_poll_seq_if bus();

  sensor_poll_seq #(
    .NREAD(NREAD), .BASE_REG(BASE), .HUM_REG(HUMR), .MEAS_REG(MEASR),
    .CONV_CYCLES(32'd20), .PERIOD_CYCLES(32'd200), .TIMEOUT_CYCLES(32'd500)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .cfg_ctrl_hum(hum), .cfg_ctrl_meas(meas), .bus(bus),
    .busy(busy), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_count(sample_count), .nack_err(nack_err), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave knobs and bookkeeping
  int aw_dly = 0, w_dly = 0, ar_dly = 0, nack_idx = -1;
  bit no_rvalid = 0;
  int aw_age, w_age, ar_age, b_cd, r_cd;
  bit aw_got, w_got, aw_f, w_f, b_f, ar_f, r_f, r_nack;
  logic [7:0]  r_reg;
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int sv_cyc[$], aw_rise[$];
  int cyc = 0, viol = 0, sv_cnt = 0;
  logic awv_q, wv_q, arv_q;
  logic [31:0] awa_q, wd_q, ara_q;

  // Bridge model: runs on the falling edge, predicts transfers for the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_arready = 0;
      bus.b_valid = 0; bus.axi_rvalid = 0; bus.axi_rdata = '0;
      aw_age = 0; w_age = 0; ar_age = 0; b_cd = 0; r_cd = 0;
      aw_got = 0; w_got = 0; aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      awv_q = 0; wv_q = 0; arv_q = 0; awa_q = '0; wd_q = '0; ara_q = '0;
    end else begin
      // valid must hold with stable payload until transfer, then drop
      if (awv_q && !aw_f && (!bus.axi_awvalid || bus.axi_awaddr !== awa_q)) viol++;
      if (wv_q  && !w_f  && (!bus.axi_wvalid  || bus.axi_wdata  !== wd_q))  viol++;
      if (arv_q && !ar_f && (!bus.axi_arvalid || bus.axi_araddr !== ara_q)) viol++;
      if (aw_f && bus.axi_awvalid) viol++;
      if (w_f  && bus.axi_wvalid)  viol++;
      if (ar_f && bus.axi_arvalid) viol++;

      if (aw_f) begin bus.axi_awready = 0; aw_got = 1; aw_age = 0; end
      if (w_f)  begin bus.axi_wready  = 0; w_got  = 1; w_age  = 0; end
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_cd = LAT; end
      if (b_f) bus.b_valid = 0;
      if (ar_f) begin bus.axi_arready = 0; ar_age = 0; r_cd = LAT; end
      if (r_f) bus.axi_rvalid = 0;

      if (b_cd > 0) begin b_cd--; if (b_cd == 0) bus.b_valid = 1; end
      if (r_cd > 0) begin
        r_cd--;
        if (r_cd == 0 && !no_rvalid) begin
          bus.axi_rvalid = 1;
          bus.axi_rdata  = {23'd0, r_nack, r_reg ^ 8'h5A};
        end
      end

      if (bus.axi_awvalid && !bus.axi_awready) begin
        if (aw_age >= aw_dly) bus.axi_awready = 1; else aw_age++;
      end
      if (bus.axi_wvalid && !bus.axi_wready) begin
        if (w_age >= w_dly) bus.axi_wready = 1; else w_age++;
      end
      if (bus.axi_arvalid && !bus.axi_arready) begin
        if (ar_age >= ar_dly) bus.axi_arready = 1; else ar_age++;
      end

      aw_f = bus.axi_awvalid && bus.axi_awready;
      if (aw_f) aw_log.push_back(bus.axi_awaddr);
      w_f = bus.axi_wvalid && bus.axi_wready;
      if (w_f) w_log.push_back(bus.axi_wdata);
      b_f = bus.b_valid && bus.b_ready;
      ar_f = bus.axi_arvalid && bus.axi_arready;
      if (ar_f) begin
        r_reg  = bus.axi_araddr[9:2];
        r_nack = (ar_log.size() == nack_idx);
        ar_log.push_back(bus.axi_araddr);
      end
      r_f = bus.axi_rvalid && bus.axi_rready;

      if (sample_valid) begin sv_cnt++; sv_cyc.push_back(cyc); end
      if (bus.axi_awvalid && !awv_q) aw_rise.push_back(cyc);
      awv_q = bus.axi_awvalid; awa_q = bus.axi_awaddr;
      wv_q  = bus.axi_wvalid;  wd_q  = bus.axi_wdata;
      arv_q = bus.axi_arvalid; ara_q = bus.axi_araddr;
    end
  end

  // Reference: byte i of a sample is register (BASE+i mod 256) xor 0x5A.
  function automatic logic [63:0] exp_sample();
    logic [63:0] r;
    logic [7:0]  rg;
    r = '0;
    for (int i = 0; i < NREAD; i++) begin
      rg = BASE + 8'(i);
      r[i*8 +: 8] = rg ^ 8'h5A;
    end
    return r;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_sv(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      if (sample_valid) ok = 1;
    end
  endtask

  int exp_cnt = 0;

  task automatic begin_sample();
    aw_log.delete(); w_log.delete(); ar_log.delete();
    start = 1; step(); start = 0;
  endtask

  task automatic finish_sample(input string tag, input logic [7:0] h, input logic [7:0] m);
    bit ok;
    int sv0;
    sv0 = sv_cnt;
    wait_sv(3000, ok);
    chk({tag, "_done"}, ok, 1);
    step(2);
    exp_cnt++;
    chk({tag, "_count"}, sample_count, exp_cnt);
    chk({tag, "_pulses"}, sv_cnt - sv0, 1);
    chk({tag, "_data"}, sample_data, exp_sample());
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nwr"}, {aw_log.size(), w_log.size()}, {32'd2, 32'd2});
    if (aw_log.size() == 2 && w_log.size() == 2) begin
      chk({tag, "_wr0"}, {aw_log[0], w_log[0]}, {32'(HUMR) * 4, 24'd0, h});
      chk({tag, "_wr1"}, {aw_log[1], w_log[1]}, {32'(MEASR) * 4, 24'd0, m});
    end
    chk({tag, "_nrd"}, ar_log.size(), NREAD);
    for (int i = 0; i < ar_log.size() && i < NREAD; i++)
      chk({tag, "_rd"}, ar_log[i], 32'(8'(BASE + 8'(i))) * 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int c0, t0, n_aw;
    logic [63:0] saved;
    rst = 0; enable = 0; start = 0; hum = 0; meas = 0;
    step(3);
    chk("rst_data", sample_data, 0);
    chk("rst_flags", {sample_valid, nack_err, timeout_err, busy, sample_count}, 0);
    chk("rst_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_rready, bus.b_ready}, 0);
    chk("rst_addr", {bus.axi_awaddr, bus.axi_araddr} | 64'(bus.axi_wdata), 0);
    rst = 1; step(2);
    chk("idle_busy", busy, 0);

    // one-shot with fixed configuration
    hum = 8'h01; meas = 8'h27;
    begin_sample();
    chk("os_busy", busy, 1);
    finish_sample("oneshot", 8'h01, 8'h27);
    chk("os_byte0", sample_data[7:0], 8'hAD);
    chk("os_byte7", sample_data[63:56], 8'hA4);

    // randomized configuration and ready delays
    for (int k = 0; k < 4; k++) begin
      hum = 8'($urandom); meas = 8'($urandom);
      aw_dly = $urandom_range(0, 6); w_dly = $urandom_range(0, 6); ar_dly = $urandom_range(0, 6);
      begin_sample();
      finish_sample("rand", hum, meas);
    end

    // split write handshake: wready five cycles ahead of awready
    aw_dly = 5; w_dly = 0; ar_dly = 0; viol = 0;
    begin_sample();
    finish_sample("split", hum, meas);
    chk("split_protocol", viol, 0);
    aw_dly = 0;

    // NACK on the third read, cleared by the next start
    nack_idx = 2;
    begin_sample();
    finish_sample("nack", hum, meas);
    chk("nack_set", nack_err, 1);
    nack_idx = -1;
    begin_sample();
    chk("nack_clear", nack_err, 0);
    finish_sample("nack2", hum, meas);
    chk("nack_stays_clear", nack_err, 0);

    // watchdog on a read that never returns
    no_rvalid = 1; saved = sample_data; c0 = sv_cnt;
    begin_sample();
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin step(); if (bus.axi_rready) ok = 1; end
    chk("tmo_reach_rdr", ok, 1);
    t0 = cyc; ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin step(); if (timeout_err) ok = 1; end
    chk("tmo_flag", ok, 1);
    chk("tmo_cycles", cyc - t0, TMO);
    chk("tmo_idle", {busy, bus.axi_rready, bus.axi_arvalid}, 0);
    step(2);
    chk("tmo_data", sample_data, saved);
    chk("tmo_no_valid", sv_cnt - c0, 0);
    no_rvalid = 0;
    step(5);
    begin_sample();
    chk("tmo_clear", timeout_err, 0);
    finish_sample("post_tmo", hum, meas);

    // periodic sampling
    sv_cyc.delete(); aw_rise.delete(); aw_log.delete(); w_log.delete(); ar_log.delete();
    c0 = sample_count;
    enable = 1;
    for (int s = 0; s < 3; s++) begin
      wait_sv(3000, ok);
      chk("per_sample", ok, 1);
    end
    chk("per_count", sample_count, c0 + 3);
    exp_cnt = exp_cnt + 3;
    chk("per_data", sample_data, exp_sample());
    chk("per_rises", aw_rise.size() >= 5, 1);
    if (aw_rise.size() >= 5 && sv_cyc.size() >= 2) begin
      chk("per_gap0", aw_rise[2] - sv_cyc[0], PERIOD);
      chk("per_gap1", aw_rise[4] - sv_cyc[1], PERIOD);
    end
    step(50);
    enable = 0;
    n_aw = aw_log.size();
    step(400);
    chk("per_stop_writes", aw_log.size(), n_aw);
    chk("per_stop_idle", busy, 0);
    chk("per_stop_count", sample_count, c0 + 3);

    // reset pulse while a read response is outstanding
    begin_sample();
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin step(); if (bus.axi_rready) ok = 1; end
    chk("mrst_reach_rdr", ok, 1);
    rst = 0; step();
    chk("mrst_count", sample_count, 0);
    chk("mrst_data", sample_data, 0);
    chk("mrst_flags", {busy, sample_valid, nack_err, timeout_err}, 0);
    chk("mrst_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_rready, bus.b_ready}, 0);
    rst = 1; exp_cnt = 0;
    step(2);
    begin_sample();
    finish_sample("post_rst", hum, meas);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
